ps2_event_receiver: RTL and testbench
=====================================

# ps2_event_receiver

Parametrised PS/2 keyboard receiver that supersedes the single-code PS/2 controller. It deserialises 11-bit PS/2 frames, folds the 0xE0 (extended) and 0xF0 (break) prefixes into per-event flags, and queues complete key events in an internal FIFO with a valid/ready output handshake. It adds frame-timeout recovery and error reporting, and sits between the PS/2 pins and any consumer (LCD/LED/UART logic) in the Clock_50 domain.

## Interface
- FIFO_DEPTH, 8: event FIFO entries; power of two, ≥ 2.
- TIMEOUT_CYCLES, 100000: Clock_50 cycles without a PS/2 falling edge before a partial frame is abandoned (2 ms at 50 MHz).
- Clock_50  input  1  system clock; the only clock.
- Reset  input  1  asynchronous, active-high reset.
- PS2_clock  input  1  raw PS/2 clock pin (asynchronous).
- PS2_data  input  1  raw PS/2 data pin (asynchronous).
- Event_code  output  8  scan code at the FIFO head.
- Event_break  output  1  head event is a break (key release).
- Event_extended  output  1  head event carried the 0xE0 prefix.
- Event_valid  output  1  FIFO non-empty; the head fields are valid.
- Event_ready  input  1  consumer accepts the head this cycle.
- Fifo_count  output  $clog2(FIFO_DEPTH+1)  occupied entries.
- Frame_error  output  1  one-cycle pulse: bad stop bit, timeout, or (if enabled) bad parity.
- Overflow  output  1  one-cycle pulse: complete event dropped because the FIFO was full.

## Operation
- PS2_clock and PS2_data each pass through a 2-flop synchroniser. A falling edge is detected when the synchronised clock is 0 and its previous value was 1; data is sampled on that cycle.
- States S_IDLE, S_DATA, S_PARITY, S_STOP, evaluated only on falling-edge cycles (except for timeout):
  - S_IDLE: data 0 (start bit) → S_DATA, clear shift register and bit counter; data 1 → stay.
  - S_DATA: shift LSB-first (new bit into bit 7, shift right); after the 8th bit → S_PARITY.
  - S_PARITY: store the parity bit → S_STOP.
  - S_STOP: always → S_IDLE. Data 1 (and parity OK if enabled) → frame accepted; otherwise → Frame_error.
- Accepted frame processing:
  - 0xE0 sets ext_pending. 0xF0 sets brk_pending. Neither is queued.
  - Any other code pushes {code, brk_pending, ext_pending} into the FIFO and clears both pending flags.
- Any Frame_error also clears ext_pending and brk_pending.
- Timeout: a down-counter reloads to TIMEOUT_CYCLES−1 on every falling edge. When it reaches 0 in a non-IDLE state → S_IDLE, partial frame discarded, Frame_error pulse. The counter is held reloaded while in S_IDLE.
- FIFO is first-word-fall-through. Pop occurs when Event_valid && Event_ready.
- Push while full:
  - Without a simultaneous pop → event dropped, Overflow pulse, contents unchanged.
  - With a simultaneous pop → push accepted, no overflow.
- Pop while empty is ignored. Read and write pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: all outputs 0, state S_IDLE, pending flags 0, FIFO empty, synchroniser flops 1 (idle bus).
- Reset mid-frame discards the frame and FIFO contents immediately (asynchronous).
- Pin to edge detect: 2–3 cycles of synchroniser delay.
- Stop-bit edge-detect cycle E: FIFO write at the clock edge ending E. Event_valid, head fields and Fifo_count update from E+1. Frame_error and Overflow are high during E+1 only.
- Pop at cycle P: next head (or Event_valid=0) visible from P+1.
- Simultaneous push and pop on a non-empty FIFO: Fifo_count unchanged.
- Simultaneous push and pop on an empty FIFO: the pop is ignored and the push is kept.

## Configuration
- PS2_PARITY_CHECK_EN defined: odd parity is checked over the 8 data bits plus the parity bit. A mismatch at S_STOP causes Frame_error and the frame is discarded.
- PS2_PARITY_CHECK_EN undefined: the parity bit is sampled and ignored, and no parity logic is synthesised.

## Structure
- Package ps2_pkg contains:
  - state enum ps2_rx_state_t
  - constants PS2_EXT_PREFIX = 8'hE0 and PS2_BRK_PREFIX = 8'hF0
  - packed struct ps2_event_t {code[7:0], brk, ext}
- One sub-module, ps2_event_fifo, parametrised by FIFO_DEPTH, with push/pop/full/empty/count. Top level holds the synchroniser, frame FSM, timeout counter and prefix logic.

## Test plan
- Frame 0x1C (parity 0, stop 1), Event_ready=1 → one event: code 0x1C, break 0, extended 0; Frame_error 0.
- Frames F0, 1C → single event 0x1C with break 1, extended 0; Fifo_count peaks at 1.
- Frames E0, F0, 75 → single event 0x75 with break 1, extended 1. A following frame 75 → break 0, extended 0.
- Frame 0x1C with parity bit 1:
  - Macro defined → Frame_error pulse, no event.
  - Macro undefined → event 0x1C delivered.
- Event_ready=0, send FIFO_DEPTH+1 distinct codes:
  - Fifo_count reaches FIFO_DEPTH and Overflow pulses once on the last code.
  - Draining returns the first FIFO_DEPTH codes in order.
  - Push and pop on the same cycle while full → no Overflow.
- Start bit plus 4 data bits, then bus idle for TIMEOUT_CYCLES+10 → Frame_error pulse and return to S_IDLE. A subsequent 0x29 frame is received correctly. Reset asserted mid-frame clears all outputs.

Source files
------------

// File: rtl/ps2_pkg.sv
// ============================================================================
// Module   : ps2_pkg
// Purpose  : Shared types and constants for the PS/2 event receiver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ps2_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } ps2_rx_state_t;

  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;

  typedef struct packed {
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } ps2_event_t;

  // Odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_event_fifo.sv
// ============================================================================
// Module   : ps2_event_fifo
// Purpose  : First-word-fall-through event FIFO; a push into a full FIFO is
//            accepted only when a pop happens in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [9:0]    wdata_i,
  input  logic          pop_i,
  output logic [9:0]    rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o,
  output logic          overflow_o
);

  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          w_do_push;
  logic          w_do_pop;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CW'(FIFO_DEPTH));
  assign w_do_pop  = pop_i && !empty_o;
  assign w_do_push = push_i && (!full_o || w_do_pop);

  assign overflow_o = push_i && !w_do_push;
  assign count_o    = count_q;
  assign rdata_o    = empty_o ? 10'd0 : mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (w_do_push && !w_do_pop) begin
      count_d = count_q + CW'(1);
    end else if (w_do_pop && !w_do_push) begin
      count_d = count_q - CW'(1);
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (w_do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (w_do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ps2_event_receiver.sv
// ============================================================================
// Module   : ps2_event_receiver
// Purpose  : PS/2 keyboard frame receiver with E0/F0 prefix folding, timeout
//            recovery and an event FIFO. Optional macro: PS2_PARITY_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_event_receiver
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          Clock_50,
  input  logic          Reset,
  input  logic          PS2_clock,
  input  logic          PS2_data,
  output logic [7:0]    Event_code,
  output logic          Event_break,
  output logic          Event_extended,
  output logic          Event_valid,
  input  logic          Event_ready,
  output logic [CW-1:0] Fifo_count,
  output logic          Frame_error,
  output logic          Overflow
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_RELOAD = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    ps2c_sync_q;
  logic [1:0]    ps2d_sync_q;
  logic          ps2c_prev_q;
  ps2_rx_state_t state_q;
  logic [7:0]    shift_q;
  logic [2:0]    bit_cnt_q;
  logic [TW-1:0] tmo_q;
  logic [TW-1:0] tmo_d;
  logic          ext_pending_q;
  logic          brk_pending_q;
  logic          frame_error_q;
  logic          overflow_q;

  logic          w_fall;
  logic          w_data;
  logic          w_parity_ok;
  logic          w_stop_edge;
  logic          w_accept;
  logic          w_timeout;
  logic          w_frame_err;
  logic          w_is_prefix;
  logic          w_push;
  logic [9:0]    w_wdata;
  logic [9:0]    w_rdata;
  logic          w_full;
  logic          w_empty;
  logic          w_fifo_ovf;
  ps2_event_t    w_event_in;
  ps2_event_t    w_event_out;

  assign w_fall = !ps2c_sync_q[1] && ps2c_prev_q;
  assign w_data = ps2d_sync_q[1];

`ifdef PS2_PARITY_CHECK_EN
  logic parity_q;
  assign w_parity_ok = odd_parity_ok(shift_q, parity_q);
`else
  assign w_parity_ok = 1'b1;
`endif

  assign w_stop_edge = (state_q == S_STOP) && w_fall;
  assign w_accept    = w_stop_edge && w_data && w_parity_ok;
  assign w_timeout   = (state_q != S_IDLE) && !w_fall && (tmo_q == '0);
  assign w_frame_err = (w_stop_edge && !(w_data && w_parity_ok)) || w_timeout;
  assign w_is_prefix = (shift_q == PS2_EXT_PREFIX) || (shift_q == PS2_BRK_PREFIX);
  assign w_push      = w_accept && !w_is_prefix;

  assign w_event_in = '{code: shift_q, brk: brk_pending_q, ext: ext_pending_q};
  assign w_wdata    = w_event_in;

  always_comb begin
    tmo_d = tmo_q;
    if ((state_q == S_IDLE) || w_fall) begin
      tmo_d = TMO_RELOAD;
    end else if (tmo_q != '0) begin
      tmo_d = tmo_q - TW'(1);
    end
  end

  // Synchroniser flops idle high so reset looks like an idle bus.
  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) begin
      ps2c_sync_q <= 2'b11;
      ps2d_sync_q <= 2'b11;
      ps2c_prev_q <= 1'b1;
      tmo_q       <= TMO_RELOAD;
    end else begin
      ps2c_sync_q <= {ps2c_sync_q[0], PS2_clock};
      ps2d_sync_q <= {ps2d_sync_q[0], PS2_data};
      ps2c_prev_q <= ps2c_sync_q[1];
      tmo_q       <= tmo_d;
    end
  end

  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      ext_pending_q <= 1'b0;
      brk_pending_q <= 1'b0;
      frame_error_q <= 1'b0;
      overflow_q    <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      parity_q      <= 1'b0;
`endif
    end else begin
      frame_error_q <= w_frame_err;
      overflow_q    <= w_fifo_ovf;

      if (w_frame_err) begin
        ext_pending_q <= 1'b0;
        brk_pending_q <= 1'b0;
      end else if (w_accept) begin
        if (shift_q == PS2_EXT_PREFIX) begin
          ext_pending_q <= 1'b1;
        end else if (shift_q == PS2_BRK_PREFIX) begin
          brk_pending_q <= 1'b1;
        end else begin
          ext_pending_q <= 1'b0;
          brk_pending_q <= 1'b0;
        end
      end

      if (w_fall) begin
        case (state_q)
          S_IDLE: begin
            if (!w_data) begin
              state_q   <= S_DATA;
              shift_q   <= '0;
              bit_cnt_q <= '0;
            end
          end
          S_DATA: begin
            shift_q   <= {w_data, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= S_PARITY;
            end
          end
          S_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
            parity_q <= w_data;
`endif
            state_q <= S_STOP;
          end
          S_STOP:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end else if (w_timeout) begin
        state_q <= S_IDLE;
      end
    end
  end

  ps2_event_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (Clock_50),
    .rst_i      (Reset),
    .push_i     (w_push),
    .wdata_i    (w_wdata),
    .pop_i      (Event_ready),
    .rdata_o    (w_rdata),
    .full_o     (w_full),
    .empty_o    (w_empty),
    .count_o    (Fifo_count),
    .overflow_o (w_fifo_ovf)
  );

  assign w_event_out    = w_rdata;
  assign Event_code     = w_event_out.code;
  assign Event_break    = w_event_out.brk;
  assign Event_extended = w_event_out.ext;
  assign Event_valid    = !w_empty;
  assign Frame_error    = frame_error_q;
  assign Overflow       = overflow_q;

  logic w_unused;
  assign w_unused = w_full;

endmodule

`default_nettype wire

// File: tb/tb_ps2_event_receiver.sv
// ============================================================================
// Module   : tb_ps2_event_receiver
// Purpose  : Directed self-checking bench for ps2_event_receiver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_event_receiver;

  localparam int DEPTH = 4;
  localparam int TMO   = 200;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          Clock_50 = 1'b0;
  logic          Reset = 1'b1;
  logic          PS2_clock = 1'b1;
  logic          PS2_data = 1'b1;
  logic          Event_ready = 1'b0;
  logic [7:0]    Event_code;
  logic          Event_break;
  logic          Event_extended;
  logic          Event_valid;
  logic [CW-1:0] Fifo_count;
  logic          Frame_error;
  logic          Overflow;

  int checks = 0;
  int errors = 0;

  int         err_cnt = 0;
  int         ovf_cnt = 0;
  int         max_cnt = 0;
  int         max_req = 0;
  int         max_seen = 0;
  logic [9:0] popq[$];

  ps2_event_receiver #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .Clock_50       (Clock_50),
    .Reset          (Reset),
    .PS2_clock      (PS2_clock),
    .PS2_data       (PS2_data),
    .Event_code     (Event_code),
    .Event_break    (Event_break),
    .Event_extended (Event_extended),
    .Event_valid    (Event_valid),
    .Event_ready    (Event_ready),
    .Fifo_count     (Fifo_count),
    .Frame_error    (Frame_error),
    .Overflow       (Overflow)
  );

  always #10 Clock_50 = ~Clock_50;

  // Sample away from the active edge; a pop is seen in the cycle it occurs.
  always @(negedge Clock_50) begin
    if (!Reset) begin
      if (Frame_error) err_cnt++;
      if (Overflow) ovf_cnt++;
      if (Event_valid && Event_ready) popq.push_back({Event_code, Event_break, Event_extended});
      if (max_req != max_seen) begin
        max_seen = max_req;
        max_cnt  = 0;
      end
      if (int'(Fifo_count) > max_cnt) max_cnt = int'(Fifo_count);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge Clock_50);
    #1;
  endtask

  // With pop_pulse set, Event_ready is high for one cycle aligned to the
  // stop-bit edge detection (two synchroniser cycles after the pin falls).
  task automatic ps2_bit(input logic b, input logic pop_pulse);
    PS2_data = b;
    wait_cyc(4);
    PS2_clock = 1'b0;
    if (pop_pulse) begin
      wait_cyc(2);
      Event_ready = 1'b1;
      wait_cyc(1);
      Event_ready = 1'b0;
      wait_cyc(5);
    end else begin
      wait_cyc(8);
    end
    PS2_clock = 1'b1;
    wait_cyc(4);
  endtask

  task automatic send_frame(input logic [7:0] code, input logic bad_par, input logic pop_pulse);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(code[i], 1'b0);
    ps2_bit((~^code) ^ bad_par, 1'b0);
    ps2_bit(1'b1, pop_pulse);
    PS2_data = 1'b1;
    wait_cyc(20);
  endtask

  initial begin
    int e0;
    int p0;
    int o0;

    wait_cyc(3);
    chk("rst_valid", {31'd0, Event_valid}, 32'd0);
    chk("rst_count", {29'd0, Fifo_count}, 32'd0);
    chk("rst_code", {24'd0, Event_code}, 32'd0);
    chk("rst_ferr", {31'd0, Frame_error}, 32'd0);
    chk("rst_ovf", {31'd0, Overflow}, 32'd0);
    Reset = 1'b0;
    wait_cyc(5);

    // Plain make code
    Event_ready = 1'b1;
    e0 = err_cnt; p0 = popq.size();
    send_frame(8'h1C, 1'b0, 1'b0);
    chk("make_n", popq.size() - p0, 32'd1);
    chk("make_ev", {22'd0, popq[p0]}, {22'd0, 8'h1C, 1'b0, 1'b0});
    chk("make_ferr", err_cnt - e0, 32'd0);

    // Break prefix folded into the event
    max_req++;
    p0 = popq.size();
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    chk("brk_n", popq.size() - p0, 32'd1);
    chk("brk_ev", {22'd0, popq[p0]}, {22'd0, 8'h1C, 1'b1, 1'b0});
    chk("brk_maxcnt", max_cnt, 32'd1);

    // Extended break, then plain extended-free make clears both flags
    p0 = popq.size();
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    chk("ext_n", popq.size() - p0, 32'd2);
    chk("ext_ev0", {22'd0, popq[p0]}, {22'd0, 8'h75, 1'b1, 1'b1});
    chk("ext_ev1", {22'd0, popq[p0+1]}, {22'd0, 8'h75, 1'b0, 1'b0});

    // Parity bit inverted
    e0 = err_cnt; p0 = popq.size();
    send_frame(8'h1C, 1'b1, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
    chk("par_ferr", err_cnt - e0, 32'd1);
    chk("par_n", popq.size() - p0, 32'd0);
`else
    chk("par_ferr", err_cnt - e0, 32'd0);
    chk("par_n", popq.size() - p0, 32'd1);
    chk("par_ev", {22'd0, popq[p0]}, {22'd0, 8'h1C, 1'b0, 1'b0});
`endif

    // Fill past capacity with the consumer stalled
    Event_ready = 1'b0;
    wait_cyc(2);
    o0 = ovf_cnt; p0 = popq.size();
    send_frame(8'h15, 1'b0, 1'b0);
    send_frame(8'h16, 1'b0, 1'b0);
    send_frame(8'h1D, 1'b0, 1'b0);
    send_frame(8'h24, 1'b0, 1'b0);
    chk("full_ovf0", ovf_cnt - o0, 32'd0);
    send_frame(8'h2D, 1'b0, 1'b0);
    chk("full_count", {29'd0, Fifo_count}, DEPTH);
    chk("full_ovf", ovf_cnt - o0, 32'd1);
    chk("full_head", {24'd0, Event_code}, 32'h15);
    send_frame(8'h2C, 1'b0, 1'b1);
    chk("simul_ovf", ovf_cnt - o0, 32'd1);
    chk("simul_count", {29'd0, Fifo_count}, DEPTH);
    Event_ready = 1'b1;
    wait_cyc(10);
    chk("drain_n", popq.size() - p0, 32'd5);
    chk("drain0", {22'd0, popq[p0]},   {22'd0, 8'h15, 2'b00});
    chk("drain1", {22'd0, popq[p0+1]}, {22'd0, 8'h16, 2'b00});
    chk("drain2", {22'd0, popq[p0+2]}, {22'd0, 8'h1D, 2'b00});
    chk("drain3", {22'd0, popq[p0+3]}, {22'd0, 8'h24, 2'b00});
    chk("drain4", {22'd0, popq[p0+4]}, {22'd0, 8'h2C, 2'b00});
    chk("drain_empty", {31'd0, Event_valid}, 32'd0);

    // Partial frame abandoned by timeout
    e0 = err_cnt; p0 = popq.size();
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b1, 1'b0);
    wait_cyc(TMO + 30);
    chk("tmo_ferr", err_cnt - e0, 32'd1);
    chk("tmo_n", popq.size() - p0, 32'd0);
    send_frame(8'h29, 1'b0, 1'b0);
    chk("tmo_next_n", popq.size() - p0, 32'd1);
    chk("tmo_next_ev", {22'd0, popq[p0]}, {22'd0, 8'h29, 2'b00});

    // Reset in the middle of a frame with an event queued
    Event_ready = 1'b0;
    wait_cyc(2);
    send_frame(8'h33, 1'b0, 1'b0);
    chk("mid_count", {29'd0, Fifo_count}, 32'd1);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    PS2_clock = 1'b0;
    wait_cyc(2);
    Reset = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, Event_valid}, 32'd0);
    chk("mid_rst_count", {29'd0, Fifo_count}, 32'd0);
    chk("mid_rst_code", {24'd0, Event_code}, 32'd0);
    chk("mid_rst_ferr", {31'd0, Frame_error}, 32'd0);
    PS2_clock = 1'b1;
    PS2_data  = 1'b1;
    wait_cyc(5);
    Reset = 1'b0;
    wait_cyc(TMO + 20);
    chk("post_rst_valid", {31'd0, Event_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
